phase_seq: RTL and testbench

- Multi-cycle timing sequencer directly upstream of the CPU datapath.
- Generates the one-hot phase vector p[4:0] that drives fetch (p[0]), decode/operand latch (p[1]), execute (p[2]), memory (p[3]) and writeback (p[4]).
- Instruction length varies per opcode class; op/funct come back from the instruction register.
- Also provides run/idle control, illegal-opcode halt and a retired-instruction counter.

---
 rtl/phase_seq_pkg.sv | 27 ++
 rtl/phase_seq_if.sv | 20 ++
 rtl/phase_seq_op_class_dec.sv | 14 +
 rtl/phase_seq.sv | 73 +++++++
 tb/tb_phase_seq.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/phase_seq_pkg.sv
// phase_seq_pkg: opcodes, state/class encodings and phase indices for the phase sequencer
package phase_seq_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T0   = 3'd1;
  localparam logic [2:0] S_T1   = 3'd2;
  localparam logic [2:0] S_T2   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;
  localparam logic [2:0] S_T4   = 3'd5;
  localparam logic [2:0] S_HALT = 3'd6;
  localparam int PH_IF  = 0;
  localparam int PH_ID  = 1;
  localparam int PH_EX  = 2;
  localparam int PH_MEM = 3;
  localparam int PH_WB  = 4;
  typedef enum logic [2:0] {
    IDLE = S_IDLE, T0 = S_T0, T1 = S_T1, T2 = S_T2, T3 = S_T3, T4 = S_T4, HALT = S_HALT
  } state_e;
  typedef enum logic [2:0] {CLS_R, CLS_LW, CLS_SW, CLS_BR, CLS_J, CLS_BAD} cls_e;
  function automatic logic is_last(state_e s, cls_e c);
    return s == T4 || (s == T3 && c == CLS_SW) || (s == T2 && (c == CLS_BR || c == CLS_J));
  endfunction
endpackage

// File: rtl/phase_seq_if.sv
// phase_seq_if: control/status bundle of the phase sequencer; step_mode/step exist only with SINGLE_STEP_EN
interface phase_seq_if #(parameter int CNT_W = 16);
  logic             run;
  logic [5:0]       op;
  logic [5:0]       funct;
  logic [4:0]       p;
  logic             busy;
  logic             instr_done;
  logic             illegal;
  logic [CNT_W-1:0] instr_cnt;
`ifdef SINGLE_STEP_EN
  logic             step_mode;
  logic             step;
  modport master (output run, op, funct, step_mode, step, input p, busy, instr_done, illegal, instr_cnt);
  modport slave (input run, op, funct, step_mode, step, output p, busy, instr_done, illegal, instr_cnt);
`else
  modport master (output run, op, funct, input p, busy, instr_done, illegal, instr_cnt);
  modport slave (input run, op, funct, output p, busy, instr_done, illegal, instr_cnt);
`endif
endinterface

// File: rtl/phase_seq_op_class_dec.sv
// op_class_dec: combinational opcode to instruction-class decoder
module op_class_dec
  import phase_seq_pkg::*;
(
  input  logic [5:0] op,
  output cls_e       cls
);
  always_comb
    cls = op == OP_RTYPE ? CLS_R  :
          op == OP_LW    ? CLS_LW :
          op == OP_SW    ? CLS_SW :
          op == OP_BEQ   ? CLS_BR :
          op == OP_J     ? CLS_J  : CLS_BAD;
endmodule

// File: rtl/phase_seq.sv
// phase_seq: one-hot T0..T4 phase sequencer with per-class lengths, halt on bad opcode, retire counter (optional SINGLE_STEP_EN)
module phase_seq
  import phase_seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic        clk,
  input logic        reset,
  phase_seq_if.slave bus
);
  state_e           state_q, state_d;
  cls_e             cls_q, cls_d, dec_cls;
  logic [4:0]       p_q, p_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             issue, cont;
  logic             unused_funct;
  assign unused_funct = ^bus.funct;
`ifdef SINGLE_STEP_EN
  assign issue = bus.step_mode ? bus.step : bus.run;
  assign cont  = bus.run & ~bus.step_mode;
`else
  assign issue = bus.run;
  assign cont  = bus.run;
`endif
  op_class_dec u_dec (.op(bus.op), .cls(dec_cls));
  always_ff @(posedge clk)
    if (reset) begin
      state_q   <= IDLE;
      cls_q     <= CLS_R;
      p_q       <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      p_q       <= p_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  // done_q marks the last phase, so it alone decides the end of an instruction
  always_comb begin
    state_d   = state_q;
    cls_d     = state_q == T1 ? dec_cls : cls_q;
    illegal_d = illegal_q | (state_q == T1 && dec_cls == CLS_BAD);
    cnt_d     = done_q ? cnt_q + CNT_W'(1) : cnt_q;
    if (done_q) state_d = cont ? T0 : IDLE;
    else
      case (state_q)
        IDLE:    state_d = issue ? T0 : IDLE;
        T0:      state_d = T1;
        T1:      state_d = dec_cls == CLS_BAD ? HALT : T2;
        T2:      state_d = cls_q == CLS_R ? T4 : T3;
        T3:      state_d = T4;
        default: state_d = state_q;
      endcase
    p_d         = '0;
    p_d[PH_IF]  = state_d == T0;
    p_d[PH_ID]  = state_d == T1;
    p_d[PH_EX]  = state_d == T2;
    p_d[PH_MEM] = state_d == T3;
    p_d[PH_WB]  = state_d == T4;
    done_d      = is_last(state_d, cls_d);
  end
  assign bus.p          = p_q;
  assign bus.busy       = |p_q;
  assign bus.instr_done = done_q;
  assign bus.illegal    = illegal_q;
  assign bus.instr_cnt  = cnt_q;
endmodule

// File: tb/tb_phase_seq.sv
// tb_phase_seq: directed self-checking bench for phase_seq (CNT_W=16 and a CNT_W=4 twin for wrap)
module tb_phase_seq;
  import phase_seq_pkg::*;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  phase_seq_if #(.CNT_W(16)) b ();
  phase_seq_if #(.CNT_W(4))  b4 ();
  assign b4.run   = b.run;
  assign b4.op    = b.op;
  assign b4.funct = b.funct;
`ifdef SINGLE_STEP_EN
  assign b4.step_mode = b.step_mode;
  assign b4.step      = b.step;
`endif
  phase_seq #(.CNT_W(16)) u_dut  (.clk(clk), .reset(reset), .bus(b.slave));
  phase_seq #(.CNT_W(4))  u_dut4 (.clk(clk), .reset(reset), .bus(b4.slave));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [4:0] lw_p [5];
  logic [4:0] seq_p [10];
  logic [5:0] seq_op [10];
  logic       seq_done [10];

  initial begin
    lw_p = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
    seq_p = '{5'b00001, 5'b00010, 5'b00100, 5'b01000,
              5'b00001, 5'b00010, 5'b00100,
              5'b00001, 5'b00010, 5'b00100};
    seq_op = '{OP_SW, OP_SW, OP_SW, OP_SW, OP_BEQ, OP_BEQ, OP_BEQ, OP_J, OP_J, OP_J};
    seq_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    reset = 1'b1;
    b.run = 1'b0;
    b.op = OP_RTYPE;
    b.funct = 6'h00;
`ifdef SINGLE_STEP_EN
    b.step_mode = 1'b0;
    b.step = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;
    chk("rst_p", b.p, 0);
    chk("rst_busy", b.busy, 0);
    chk("rst_done", b.instr_done, 0);
    chk("rst_illegal", b.illegal, 0);
    chk("rst_cnt", b.instr_cnt, 0);
    // R-type: T0 T1 T2 T4 then back to T0
    b.run = 1'b1;
    b.funct = 6'h2a;
    tick(); chk("r_t0", b.p, 5'b00001);
    tick(); chk("r_t1", b.p, 5'b00010);
    tick(); chk("r_t2", b.p, 5'b00100); chk("r_t2_done", b.instr_done, 0);
    tick(); chk("r_t4", b.p, 5'b10000); chk("r_t4_done", b.instr_done, 1); chk("r_t4_cnt", b.instr_cnt, 0);
    tick(); chk("r_next_t0", b.p, 5'b00001); chk("r_cnt1", b.instr_cnt, 1); chk("r_next_done", b.instr_done, 0);
    b.run = 1'b0;
    tick(); tick(); tick();
    chk("r2_t4", b.p, 5'b10000);
    tick(); chk("r2_idle_p", b.p, 0); chk("r2_cnt", b.instr_cnt, 2);
    // LW with a one-cycle run pulse runs all five phases
    b.op = OP_LW;
    b.run = 1'b1;
    tick();
    b.run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("lw_p%0d", i), b.p, lw_p[i]);
      chk($sformatf("lw_done%0d", i), b.instr_done, i == 4);
      tick();
    end
    chk("lw_idle_p", b.p, 0);
    chk("lw_idle_busy", b.busy, 0);
    chk("lw_cnt", b.instr_cnt, 3);
    // SW, BEQ, J back to back with no gaps
    b.run = 1'b1;
    b.op = OP_SW;
    tick();
    for (int i = 0; i < 10; i++) begin
      b.op = seq_op[i];
      chk($sformatf("b2b_p%0d", i), b.p, seq_p[i]);
      chk($sformatf("b2b_done%0d", i), b.instr_done, seq_done[i]);
      if (i == 9) b.run = 1'b0;
      tick();
    end
    chk("b2b_cnt", b.instr_cnt, 6);
    chk("b2b_idle", b.p, 0);
    // Illegal opcode halts until reset
    b.op = 6'b111111;
    b.run = 1'b1;
    tick(); tick();
    chk("bad_t1", b.p, 5'b00010);
    tick();
    chk("halt_p", b.p, 0);
    chk("halt_illegal", b.illegal, 1);
    chk("halt_done", b.instr_done, 0);
    chk("halt_cnt", b.instr_cnt, 6);
    repeat (10) tick();
    chk("halt_hold_p", b.p, 0);
    chk("halt_hold_busy", b.busy, 0);
    chk("halt_hold_illegal", b.illegal, 1);
    reset = 1'b1;
    b.run = 1'b0;
    tick();
    reset = 1'b0;
    chk("halt_rst_illegal", b.illegal, 0);
    chk("halt_rst_cnt", b.instr_cnt, 0);
    tick();
    chk("halt_rst_idle", b.p, 0);
    // Reset in T3 of LW aborts it
    b.op = OP_LW;
    b.run = 1'b1;
    tick();
    b.run = 1'b0;
    tick(); tick(); tick();
    chk("abort_t3", b.p, 5'b01000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_p", b.p, 0);
    chk("abort_done", b.instr_done, 0);
    chk("abort_cnt", b.instr_cnt, 0);
    tick();
    chk("abort_stay_idle", b.p, 0);
    chk("abort_stay_cnt", b.instr_cnt, 0);
    // 16 R-types: 4-bit counter wraps to 0
    b.op = OP_RTYPE;
    b.run = 1'b1;
    tick();
    repeat (63) tick();
    chk("wrap_last_p", b.p, 5'b10000);
    chk("wrap_cnt4_pre", b4.instr_cnt, 4'hf);
    b.run = 1'b0;
    tick();
    chk("wrap_cnt4", b4.instr_cnt, 0);
    chk("wrap_cnt16", b.instr_cnt, 16);
    chk("wrap_idle", b.p, 0);
`ifdef SINGLE_STEP_EN
    b.step_mode = 1'b1;
    b.run = 1'b1;
    b.op = OP_BEQ;
    tick(); tick(); tick();
    chk("ss_wait", b.p, 0);
    b.step = 1'b1;
    tick();
    b.step = 1'b0;
    chk("ss_t0", b.p, 5'b00001);
    tick();
    chk("ss_t1", b.p, 5'b00010);
    b.step = 1'b1;
    tick();
    b.step = 1'b0;
    chk("ss_t2", b.p, 5'b00100);
    chk("ss_t2_done", b.instr_done, 1);
    tick();
    chk("ss_idle", b.p, 0);
    chk("ss_cnt", b.instr_cnt, 17);
    tick();
    chk("ss_stay_idle", b.p, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
